// File: rtl/apu_issue_unit.sv
`default_nettype none
// apu_issue_unit: queues vector commands and issues them one at a time over the APU req/gnt/rvalid
// protocol, returning each result through a valid/ready response register.
module apu_issue_unit #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmd_valid_i,
   output logic                         cmd_ready_o,
   input  logic [5:0]                   cmd_op_i,
   input  logic [14:0]                  cmd_flags_i,
   input  logic [2:0][31:0]             cmd_operands_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [31:0]                  rsp_result_o,
   output logic [4:0]                   rsp_flags_o,
   output logic                         apu_req_o,
   input  logic                         apu_gnt_i,
   output logic [5:0]                   apu_op_o,
   output logic [14:0]                  apu_flags_o,
   output logic [2:0][31:0]             apu_operands_o,
   input  logic                         apu_rvalid_i,
   input  logic [31:0]                  apu_result_i,
   input  logic [4:0]                   apu_flags_i,
   input  logic                         core_halt_i,
   output logic                         busy_o,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o,
   output logic                         error_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES+1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t state, next_state;

   logic [5:0]       op_mem    [DEPTH];
   logic [14:0]      flags_mem [DEPTH];
   logic [2:0][31:0] opnd_mem  [DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic [TMR_W-1:0] timer;
   logic             push, issue, capture;

   assign cmd_ready_o  = (count != CNT_W'(DEPTH));
   assign push         = cmd_valid_i && cmd_ready_o;
   assign fifo_count_o = count;
   assign apu_req_o    = (state == REQ);
   assign busy_o       = (state != IDLE) || (count != '0);

   // Storage carries no reset: the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr]    <= cmd_op_i;
         flags_mem[wr_ptr] <= cmd_flags_i;
         opnd_mem[wr_ptr]  <= cmd_operands_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
         if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, issue})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Issue is held off while an unconsumed response sits in the register, so a capture never overwrites one.
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if ((count != '0) && !core_halt_i && (!rsp_valid_o || rsp_ready_i)) begin
               issue      = 1'b1;
               next_state = REQ;
            end
         end
         REQ: begin
            if (apu_gnt_i) begin
               if (apu_rvalid_i) begin
                  capture    = 1'b1;
                  next_state = IDLE;
               end else begin
                  next_state = WAIT;
               end
            end
         end
         WAIT: begin
            if (apu_rvalid_i) begin
               capture    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         apu_op_o       <= '0;
         apu_flags_o    <= '0;
         apu_operands_o <= '0;
      end else if (issue) begin
         apu_op_o       <= op_mem[rd_ptr];
         apu_flags_o    <= flags_mem[rd_ptr];
         apu_operands_o <= opnd_mem[rd_ptr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_o  <= 1'b0;
         rsp_result_o <= '0;
         rsp_flags_o  <= '0;
      end else if (capture) begin
         rsp_valid_o  <= 1'b1;
         rsp_result_o <= apu_result_i;
         rsp_flags_o  <= apu_flags_i;
      end else if (rsp_ready_i) begin
         rsp_valid_o  <= 1'b0;
      end
   end

   // Timer saturates at the limit; the FSM keeps waiting so a late rvalid still completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer   <= '0;
         error_o <= 1'b0;
      end else if (issue) begin
         timer <= '0;
      end else if ((state == WAIT) && !capture && (timer != TMR_W'(TIMEOUT_CYCLES))) begin
         timer <= timer + TMR_W'(1);
         if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) error_o <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apu_issue_unit.sv
`default_nettype none
// tb_apu_issue_unit: directed scenario tests for apu_issue_unit with hand-computed expectations.
module tb_apu_issue_unit;
   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid_i, cmd_ready_o;
   logic [5:0]       cmd_op_i;
   logic [14:0]      cmd_flags_i;
   logic [2:0][31:0] cmd_operands_i;
   logic             rsp_valid_o, rsp_ready_i;
   logic [31:0]      rsp_result_o;
   logic [4:0]       rsp_flags_o;
   logic             apu_req_o, apu_gnt_i;
   logic [5:0]       apu_op_o;
   logic [14:0]      apu_flags_o;
   logic [2:0][31:0] apu_operands_o;
   logic             apu_rvalid_i;
   logic [31:0]      apu_result_i;
   logic [4:0]       apu_flags_i;
   logic             core_halt_i, busy_o, error_o;
   logic [2:0]       fifo_count_o;

   int tests = 0;
   int fails = 0;

   apu_issue_unit #(.DEPTH(4), .TIMEOUT_CYCLES(1024)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_flags_i(cmd_flags_i), .cmd_operands_i(cmd_operands_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
      .rsp_flags_o(rsp_flags_o), .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
      .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o), .apu_operands_o(apu_operands_o),
      .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i), .apu_flags_i(apu_flags_i),
      .core_halt_i(core_halt_i), .busy_o(busy_o), .fifo_count_o(fifo_count_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [5:0] op, input logic [31:0] base);
      cmd_valid_i       = 1'b1;
      cmd_op_i          = op;
      cmd_flags_i       = {9'd0, op};
      cmd_operands_i[0] = base;
      cmd_operands_i[1] = base + 32'd1;
      cmd_operands_i[2] = base + 32'd2;
      tick();
      cmd_valid_i = 1'b0;
   endtask

   // Waits (bounded) for a request, then grants and returns the result in the same cycle.
   task automatic serve_one(input logic [5:0] op, input logic [31:0] res);
      int n = 0;
      while (apu_req_o !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      tests++;
      if (apu_req_o !== 1'b1 || apu_op_o !== op) begin
         fails++;
         $display("FAIL serve_req: req=%b op=%h, expected req=1 op=%h", apu_req_o, apu_op_o, op);
      end
      apu_gnt_i = 1'b1; apu_rvalid_i = 1'b1; apu_result_i = res; apu_flags_i = res[4:0];
      tick();
      apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_result_o !== res || rsp_flags_o !== res[4:0]) begin
         fails++;
         $display("FAIL serve_rsp: valid=%b result=%h flags=%h, expected 1 %h %h",
                  rsp_valid_o, rsp_result_o, rsp_flags_o, res, res[4:0]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      tests++;
      if ({cmd_ready_o, rsp_valid_o, apu_req_o, busy_o, error_o} !== 5'b10000 || fifo_count_o !== 3'd0
          || apu_op_o !== 6'd0 || rsp_result_o !== 32'd0) begin
         fails++;
         $display("FAIL reset_state: rdy/rv/req/busy/err=%b cnt=%0d op=%h res=%h, expected 10000 0 00 0",
                  {cmd_ready_o, rsp_valid_o, apu_req_o, busy_o, error_o}, fifo_count_o, apu_op_o, rsp_result_o);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      push(6'h05, 32'd1);
      tests++;
      if (apu_req_o !== 1'b0 || fifo_count_o !== 3'd1 || busy_o !== 1'b1) begin
         fails++;
         $display("FAIL single_queued: req=%b cnt=%0d busy=%b, expected 0 1 1", apu_req_o, fifo_count_o, busy_o);
      end
      tick();
      tests++;
      if (apu_req_o !== 1'b1 || apu_op_o !== 6'h05 || apu_flags_o !== 15'h0005
          || apu_operands_o !== {32'd3, 32'd2, 32'd1} || fifo_count_o !== 3'd0) begin
         fails++;
         $display("FAIL single_issue: req=%b op=%h fl=%h opnd=%h cnt=%0d", apu_req_o, apu_op_o, apu_flags_o,
                  apu_operands_o, fifo_count_o);
      end
      apu_gnt_i = 1'b1;
      tick();
      apu_gnt_i = 1'b0;
      tests++;
      if (apu_req_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL single_req_pulse: req=%b rv=%b, expected 0 0", apu_req_o, rsp_valid_o);
      end
      tick();
      apu_rvalid_i = 1'b1; apu_result_i = 32'hDEAD_BEEF; apu_flags_i = 5'h0A;
      tick();
      apu_rvalid_i = 1'b0;
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hDEAD_BEEF || rsp_flags_o !== 5'h0A || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL single_rsp: rv=%b res=%h fl=%h busy=%b, expected 1 deadbeef 0a 0",
                  rsp_valid_o, rsp_result_o, rsp_flags_o, busy_o);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      tests++;
      if (rsp_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL single_drain: rv=%b, expected 0", rsp_valid_o);
      end
   endtask

   task automatic test_gnt_stall();
      logic ok = 1'b1;
      push(6'h11, 32'hA0);
      tick();
      for (int i = 0; i < 5; i++) begin
         // A stray rvalid without grant must be ignored.
         apu_rvalid_i = (i == 2);
         if (apu_req_o !== 1'b1 || apu_operands_o !== {32'hA2, 32'hA1, 32'hA0} || apu_op_o !== 6'h11) ok = 1'b0;
         tick();
      end
      apu_rvalid_i = 1'b0;
      tests++;
      if (!ok || apu_req_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL stall_hold: stable=%b req=%b rv=%b, expected 1 1 0", ok, apu_req_o, rsp_valid_o);
      end
      apu_gnt_i = 1'b1;
      tick();
      apu_gnt_i = 1'b0;
      apu_rvalid_i = 1'b1; apu_result_i = 32'h0000_1234; apu_flags_i = 5'h03;
      tick();
      apu_rvalid_i = 1'b0;
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h1234) begin
         fails++;
         $display("FAIL stall_rsp: rv=%b res=%h, expected 1 00001234", rsp_valid_o, rsp_result_o);
      end
      rsp_ready_i = 1'b1;
      tick();
      tick();
      rsp_ready_i = 1'b0;
      tests++;
      if (rsp_valid_o !== 1'b0 || apu_req_o !== 1'b0 || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL stall_single_rsp: rv=%b req=%b busy=%b, expected 0 0 0", rsp_valid_o, apu_req_o, busy_o);
      end
   endtask

   task automatic test_fifo_full();
      logic [2:0] exp_cnt [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
      logic       exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         push(6'h08 + 6'(i), 32'h100 * 32'(i));
         tests++;
         if (fifo_count_o !== exp_cnt[i] || cmd_ready_o !== exp_rdy[i]) begin
            fails++;
            $display("FAIL full_push%0d: cnt=%0d rdy=%b, expected %0d %b", i, fifo_count_o, cmd_ready_o,
                     exp_cnt[i], exp_rdy[i]);
         end
      end
      push(6'h3F, 32'hFFF0);
      tests++;
      if (fifo_count_o !== 3'd4 || apu_op_o !== 6'h08) begin
         fails++;
         $display("FAIL full_reject: cnt=%0d op=%h, expected 4 08", fifo_count_o, apu_op_o);
      end
      rsp_ready_i = 1'b1;
      serve_one(6'h08, 32'h8000_0008);
      // Pop while full: the concurrent push must still be refused.
      cmd_valid_i = 1'b1; cmd_op_i = 6'h3F;
      tick();
      cmd_valid_i = 1'b0;
      tests++;
      if (fifo_count_o !== 3'd3 || apu_req_o !== 1'b1 || apu_op_o !== 6'h09) begin
         fails++;
         $display("FAIL full_pop_push: cnt=%0d req=%b op=%h, expected 3 1 09", fifo_count_o, apu_req_o, apu_op_o);
      end
      for (int i = 1; i < 5; i++) serve_one(6'h08 + 6'(i), 32'h8000_0008 + 32'(i));
      tick();
      tick();
      rsp_ready_i = 1'b0;
      tests++;
      if (busy_o !== 1'b0 || fifo_count_o !== 3'd0 || apu_req_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL full_drained: busy=%b cnt=%0d req=%b rv=%b, expected 0 0 0 0",
                  busy_o, fifo_count_o, apu_req_o, rsp_valid_o);
      end
   endtask

   task automatic test_rsp_backpressure();
      push(6'h21, 32'h2100);
      push(6'h22, 32'h2200);
      serve_one(6'h21, 32'hCAFE_0021);
      for (int i = 0; i < 5; i++) tick();
      tests++;
      if (apu_req_o !== 1'b0 || fifo_count_o !== 3'd1 || rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hCAFE_0021) begin
         fails++;
         $display("FAIL bp_hold: req=%b cnt=%0d rv=%b res=%h, expected 0 1 1 cafe0021",
                  apu_req_o, fifo_count_o, rsp_valid_o, rsp_result_o);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      tests++;
      if (apu_req_o !== 1'b1 || apu_op_o !== 6'h22 || rsp_valid_o !== 1'b0 || fifo_count_o !== 3'd0) begin
         fails++;
         $display("FAIL bp_release: req=%b op=%h rv=%b cnt=%0d, expected 1 22 0 0",
                  apu_req_o, apu_op_o, rsp_valid_o, fifo_count_o);
      end
      serve_one(6'h22, 32'hCAFE_0022);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_halt();
      core_halt_i = 1'b1;
      push(6'h30, 32'h3000);
      for (int i = 0; i < 4; i++) tick();
      tests++;
      if (apu_req_o !== 1'b0 || fifo_count_o !== 3'd1) begin
         fails++;
         $display("FAIL halt_block: req=%b cnt=%0d, expected 0 1", apu_req_o, fifo_count_o);
      end
      core_halt_i = 1'b0;
      tick();
      tests++;
      if (apu_req_o !== 1'b1 || apu_op_o !== 6'h30) begin
         fails++;
         $display("FAIL halt_release: req=%b op=%h, expected 1 30", apu_req_o, apu_op_o);
      end
      rsp_ready_i = 1'b1;
      serve_one(6'h30, 32'h0000_0030);
      tick();
   endtask

   task automatic test_back_to_back();
      rsp_ready_i = 1'b1;
      push(6'h31, 32'h3100);
      push(6'h32, 32'h3200);
      serve_one(6'h31, 32'h0000_0031);
      tests++;
      if (apu_req_o !== 1'b0 || fifo_count_o !== 3'd1) begin
         fails++;
         $display("FAIL b2b_gap: req=%b cnt=%0d, expected 0 1", apu_req_o, fifo_count_o);
      end
      tick();
      tests++;
      if (apu_req_o !== 1'b1 || apu_op_o !== 6'h32 || rsp_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL b2b_issue: req=%b op=%h rv=%b, expected 1 32 0", apu_req_o, apu_op_o, rsp_valid_o);
      end
      serve_one(6'h32, 32'h0000_0032);
      tick();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_timeout();
      push(6'h3A, 32'h3A00);
      tick();
      apu_gnt_i = 1'b1;
      tick();
      apu_gnt_i = 1'b0;
      for (int i = 0; i < 1020; i++) tick();
      tests++;
      if (error_o !== 1'b0 || busy_o !== 1'b1) begin
         fails++;
         $display("FAIL timeout_early: err=%b busy=%b, expected 0 1", error_o, busy_o);
      end
      for (int i = 0; i < 8; i++) tick();
      tests++;
      if (error_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL timeout_set: err=%b rv=%b, expected 1 0", error_o, rsp_valid_o);
      end
      apu_rvalid_i = 1'b1; apu_result_i = 32'h5555_AAAA; apu_flags_i = 5'h1F;
      tick();
      apu_rvalid_i = 1'b0;
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h5555_AAAA || error_o !== 1'b1 || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL timeout_late_rsp: rv=%b res=%h err=%b busy=%b, expected 1 5555aaaa 1 0",
                  rsp_valid_o, rsp_result_o, error_o, busy_o);
      end
      rsp_ready_i = 1'b1;
      push(6'h3B, 32'h3B00);
      push(6'h3C, 32'h3C00);
      rsp_ready_i = 1'b0;
      // Asynchronous reset between edges aborts the in-flight request and empties the queue.
      #1;
      reset = 1'b1;
      #1;
      tests++;
      if (error_o !== 1'b0 || apu_req_o !== 1'b0 || fifo_count_o !== 3'd0 || rsp_valid_o !== 1'b0
          || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: err=%b req=%b cnt=%0d rv=%b busy=%b, expected 0 0 0 0 0",
                  error_o, apu_req_o, fifo_count_o, rsp_valid_o, busy_o);
      end
      tick();
      reset = 1'b0;
      tick();
      tick();
      tests++;
      if (apu_req_o !== 1'b0 || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle: req=%b busy=%b, expected 0 0", apu_req_o, busy_o);
      end
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_flags_i = '0; cmd_operands_i = '0;
      rsp_ready_i = 1'b0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
      apu_result_i = '0; apu_flags_i = '0; core_halt_i = 1'b0;
      test_reset();
      test_single();
      test_gnt_stall();
      test_fifo_full();
      test_rsp_backpressure();
      test_halt();
      test_back_to_back();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
